// File: rtl/fifo_uart_tx_if.sv
// Read-side port of the team's show-ahead synchronous FIFO, as seen by its consumer.
interface fifo_uart_tx_if #(
   parameter int WIDTH = 8
) ();
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_rd_en;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_rd_en
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops words from a show-ahead FIFO and serialises each as a UART frame:
// start bit, LSB-first data, optional parity, then 1 or 2 stop bits.
module fifo_uart_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   fifo_uart_tx_if.master        fifo,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int   BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int   BIT_W  = $clog2(WIDTH + 1);
   localparam logic ODD    = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t             state, state_next;
   logic [BAUD_W-1:0]  baud_cnt, baud_next;
   logic [BIT_W-1:0]   bit_cnt, bit_next;
   logic [WIDTH-1:0]   shift, shift_next, shifted;
   logic               par_bit, par_next;
   logic               tx_next, done_next, busy_next;
   logic               rd_en;
   logic               bit_end;

   assign bit_end         = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
   assign shifted         = shift >> 1;
   assign busy_next       = (state_next != S_IDLE);
   assign fifo.fifo_rd_en = rd_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_cnt  <= bit_next;
         shift    <= shift_next;
         par_bit  <= par_next;
         tx       <= tx_next;
         busy     <= busy_next;
         tx_done  <= done_next;
      end
   end

   // tx is registered, so each branch computes the line level for the next cycle.
   // The stop phase reuses bit_cnt to count stop bits.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_cnt;
      shift_next = shift;
      par_next   = par_bit;
      tx_next    = tx;
      done_next  = 1'b0;
      rd_en      = 1'b0;

      if (state != S_IDLE) begin
         baud_next = bit_end ? '0 : baud_cnt + BAUD_W'(1);
      end

      case (state)
         S_IDLE: begin
            rd_en   = en & ~fifo.fifo_empty & ~reset;
            tx_next = 1'b1;
            if (rd_en) begin
               shift_next = fifo.fifo_data;
               par_next   = (^fifo.fifo_data) ^ ODD;
               tx_next    = 1'b0;
               baud_next  = '0;
               bit_next   = '0;
               state_next = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               tx_next    = shift[0];
               bit_next   = '0;
               state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                  bit_next = '0;
                  if (PARITY != 0) begin
                     tx_next    = par_bit;
                     state_next = S_PARITY;
                  end else begin
                     tx_next    = 1'b1;
                     state_next = S_STOP;
                  end
               end else begin
                  bit_next   = bit_cnt + BIT_W'(1);
                  shift_next = shifted;
                  tx_next    = shifted[0];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               tx_next    = 1'b1;
               bit_next   = '0;
               state_next = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                  bit_next   = '0;
                  done_next  = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  bit_next = bit_cnt + BIT_W'(1);
               end
            end
         end
         default: begin
            tx_next    = 1'b1;
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Four fifo_uart_tx instances (no parity, even, odd, two stop bits) at 4 clocks/bit,
// each fed by a small array-based show-ahead FIFO model.
module tb_fifo_uart_tx;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] en    = '0;
   logic [3:0] tx, busy, tx_done, rd;

   logic [7:0] mem [4][16];
   int         wrp [4];
   int         rdp [4];
   int         popcnt [4];

   int checks = 0;
   int passes = 0;

   logic cap_tx [128];
   logic cap_busy [128];
   logic cap_done [128];
   logic cap_rd [128];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : u
      localparam int P = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
      localparam int S = (g == 3) ? 2 : 1;
      fifo_uart_tx_if #(.WIDTH(8)) fif ();
      assign fif.fifo_empty = (wrp[g] == rdp[g]);
      assign fif.fifo_data  = mem[g][rdp[g] % 16];
      assign rd[g]          = fif.fifo_rd_en;
      fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(P), .STOP_BITS(S)) dut (
         .clk     (clk),
         .reset   (reset),
         .en      (en[g]),
         .fifo    (fif.master),
         .tx      (tx[g]),
         .busy    (busy[g]),
         .tx_done (tx_done[g])
      );
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rd[i]) begin
            rdp[i]    <= rdp[i] + 1;
            popcnt[i] <= popcnt[i] + 1;
         end
      end
   end

   // Expected line level for frame bit slot idx (0 = start bit).
   function automatic logic frame_bit(logic [7:0] d, int par, int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (idx == 9 && par == 1) return ^d;
      if (idx == 9 && par == 2) return ~^d;
      return 1'b1;
   endfunction

   task automatic push(int g, logic [7:0] v);
      mem[g][wrp[g] % 16] = v;
      wrp[g] = wrp[g] + 1;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic capture(int g, int from, int to);
      for (int c = from; c <= to; c++) begin
         step();
         cap_tx[c]   = tx[g];
         cap_busy[c] = busy[g];
         cap_done[c] = tx_done[g];
         cap_rd[c]   = rd[g];
      end
   endtask

   task automatic test_reset();
      step();
      step();
      checks++; if (tx !== 4'hF) $display("[TB] FAIL rst_tx got %b want 1111", tx); else passes++;
      checks++; if (busy !== 4'h0) $display("[TB] FAIL rst_busy got %b want 0000", busy); else passes++;
      checks++; if (tx_done !== 4'h0) $display("[TB] FAIL rst_done got %b want 0000", tx_done); else passes++;
      push(0, 8'hA5);
      en[0] = 1'b1;
      #1;
      checks++; if (rd[0] !== 1'b0) $display("[TB] FAIL rd_in_reset got %b want 0", rd[0]); else passes++;
      reset = 1'b0;
      #1;
      checks++; if (rd[0] !== 1'b1) $display("[TB] FAIL rd_after_release got %b want 1", rd[0]); else passes++;
   endtask

   task automatic test_single_frame();
      int nbusy, ndone, nrd;
      capture(0, 1, 41);
      nbusy = 0; ndone = 0; nrd = 0;
      for (int c = 1; c <= 40; c++) begin
         checks++;
         if (cap_tx[c] !== frame_bit(8'hA5, 0, (c - 1) / 4))
            $display("[TB] FAIL a5_tx cycle %0d got %b want %b", c, cap_tx[c], frame_bit(8'hA5, 0, (c - 1) / 4));
         else passes++;
      end
      for (int c = 1; c <= 41; c++) begin
         nbusy += int'(cap_busy[c]);
         ndone += int'(cap_done[c]);
         nrd   += int'(cap_rd[c]);
      end
      checks++; if (nbusy != 40) $display("[TB] FAIL a5_busy_len got %0d want 40", nbusy); else passes++;
      checks++; if (cap_done[41] !== 1'b1 || ndone != 1) $display("[TB] FAIL a5_done got %b count %0d want 1 count 1", cap_done[41], ndone); else passes++;
      checks++; if (cap_tx[41] !== 1'b1) $display("[TB] FAIL a5_idle_tx got %b want 1", cap_tx[41]); else passes++;
      checks++; if (nrd != 0 || popcnt[0] != 1) $display("[TB] FAIL a5_pops got %0d/%0d want 0/1", nrd, popcnt[0]); else passes++;
   endtask

   task automatic test_back_to_back();
      int nbusy, nrd;
      en[0] = 1'b0;
      push(0, 8'h00);
      push(0, 8'hFF);
      step();
      step();
      step();
      checks++; if (rd[0] !== 1'b0) $display("[TB] FAIL b2b_gated_rd got %b want 0", rd[0]); else passes++;
      en[0] = 1'b1;
      #1;
      checks++; if (rd[0] !== 1'b1) $display("[TB] FAIL b2b_first_pop got %b want 1", rd[0]); else passes++;
      capture(0, 1, 90);
      for (int c = 1; c <= 40; c++) begin
         checks++;
         if (cap_tx[c] !== frame_bit(8'h00, 0, (c - 1) / 4))
            $display("[TB] FAIL b2b_f1_tx cycle %0d got %b want %b", c, cap_tx[c], frame_bit(8'h00, 0, (c - 1) / 4));
         else passes++;
      end
      for (int c = 42; c <= 81; c++) begin
         checks++;
         if (cap_tx[c] !== frame_bit(8'hFF, 0, (c - 42) / 4))
            $display("[TB] FAIL b2b_f2_tx cycle %0d got %b want %b", c, cap_tx[c], frame_bit(8'hFF, 0, (c - 42) / 4));
         else passes++;
      end
      nbusy = 0; nrd = 0;
      for (int c = 1; c <= 90; c++) begin
         nbusy += int'(cap_busy[c]);
         nrd   += int'(cap_rd[c]);
      end
      checks++; if (cap_tx[41] !== 1'b1 || cap_tx[42] !== 1'b0) $display("[TB] FAIL b2b_start_gap got %b%b want 10", cap_tx[41], cap_tx[42]); else passes++;
      checks++; if (cap_rd[41] !== 1'b1 || cap_done[41] !== 1'b1) $display("[TB] FAIL b2b_pop_on_done got rd %b done %b want 1 1", cap_rd[41], cap_done[41]); else passes++;
      checks++; if (nrd != 1) $display("[TB] FAIL b2b_pop_count got %0d want 1", nrd); else passes++;
      checks++; if (nbusy != 80) $display("[TB] FAIL b2b_busy got %0d want 80", nbusy); else passes++;
      checks++; if (cap_done[82] !== 1'b1) $display("[TB] FAIL b2b_done2 got %b want 1", cap_done[82]); else passes++;
      checks++; if (wrp[0] != rdp[0]) $display("[TB] FAIL b2b_fifo_empty got wr %0d rd %0d want equal", wrp[0], rdp[0]); else passes++;
   endtask

   task automatic test_parity();
      int nbusy;
      en[1] = 1'b1;
      push(1, 8'h07);
      #1;
      checks++; if (rd[1] !== 1'b1) $display("[TB] FAIL even07_pop got %b want 1", rd[1]); else passes++;
      capture(1, 1, 45);
      for (int c = 1; c <= 44; c++) begin
         checks++;
         if (cap_tx[c] !== frame_bit(8'h07, 1, (c - 1) / 4))
            $display("[TB] FAIL even07_tx cycle %0d got %b want %b", c, cap_tx[c], frame_bit(8'h07, 1, (c - 1) / 4));
         else passes++;
      end
      nbusy = 0;
      for (int c = 1; c <= 45; c++) nbusy += int'(cap_busy[c]);
      checks++; if (cap_tx[37] !== 1'b1) $display("[TB] FAIL even07_parity got %b want 1", cap_tx[37]); else passes++;
      checks++; if (nbusy != 44) $display("[TB] FAIL even07_len got %0d want 44", nbusy); else passes++;
      checks++; if (cap_done[45] !== 1'b1) $display("[TB] FAIL even07_done got %b want 1", cap_done[45]); else passes++;

      push(1, 8'h00);
      #1;
      checks++; if (rd[1] !== 1'b1) $display("[TB] FAIL even00_pop got %b want 1", rd[1]); else passes++;
      capture(1, 1, 45);
      for (int c = 37; c <= 40; c++) begin
         checks++; if (cap_tx[c] !== 1'b0) $display("[TB] FAIL even00_parity cycle %0d got %b want 0", c, cap_tx[c]); else passes++;
      end

      en[2] = 1'b1;
      push(2, 8'h07);
      #1;
      checks++; if (rd[2] !== 1'b1) $display("[TB] FAIL odd07_pop got %b want 1", rd[2]); else passes++;
      capture(2, 1, 45);
      for (int c = 1; c <= 44; c++) begin
         checks++;
         if (cap_tx[c] !== frame_bit(8'h07, 2, (c - 1) / 4))
            $display("[TB] FAIL odd07_tx cycle %0d got %b want %b", c, cap_tx[c], frame_bit(8'h07, 2, (c - 1) / 4));
         else passes++;
      end
      checks++; if (cap_tx[37] !== 1'b0) $display("[TB] FAIL odd07_parity got %b want 0", cap_tx[37]); else passes++;
      checks++; if (cap_done[45] !== 1'b1) $display("[TB] FAIL odd07_done got %b want 1", cap_done[45]); else passes++;
   endtask

   task automatic test_two_stop();
      int nbusy;
      en[3] = 1'b1;
      push(3, 8'h3C);
      #1;
      checks++; if (rd[3] !== 1'b1) $display("[TB] FAIL stop2_pop got %b want 1", rd[3]); else passes++;
      capture(3, 1, 45);
      for (int c = 1; c <= 44; c++) begin
         checks++;
         if (cap_tx[c] !== frame_bit(8'h3C, 0, (c - 1) / 4))
            $display("[TB] FAIL stop2_tx cycle %0d got %b want %b", c, cap_tx[c], frame_bit(8'h3C, 0, (c - 1) / 4));
         else passes++;
      end
      nbusy = 0;
      for (int c = 1; c <= 45; c++) nbusy += int'(cap_busy[c]);
      checks++; if (nbusy != 44) $display("[TB] FAIL stop2_len got %0d want 44", nbusy); else passes++;
      checks++; if (cap_done[44] !== 1'b0 || cap_done[45] !== 1'b1) $display("[TB] FAIL stop2_done got %b%b want 01", cap_done[44], cap_done[45]); else passes++;
   endtask

   task automatic test_enable_gating();
      int nrd, nlow, ndone;
      en[0] = 1'b0;
      push(0, 8'h55);
      nrd = 0; nlow = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         nrd  += int'(rd[0]);
         nlow += int'(!tx[0]);
      end
      checks++; if (nrd != 0) $display("[TB] FAIL gate_no_pop got %0d want 0", nrd); else passes++;
      checks++; if (nlow != 0) $display("[TB] FAIL gate_tx_idle got %0d low cycles want 0", nlow); else passes++;
      en[0] = 1'b1;
      #1;
      checks++; if (rd[0] !== 1'b1) $display("[TB] FAIL gate_pop_on_en got %b want 1", rd[0]); else passes++;
      capture(0, 1, 10);
      checks++; if (cap_tx[1] !== 1'b0) $display("[TB] FAIL gate_start_bit got %b want 0", cap_tx[1]); else passes++;
      en[0] = 1'b0;
      push(0, 8'h81);
      push(0, 8'hC3);
      capture(0, 11, 60);
      for (int c = 1; c <= 40; c++) begin
         checks++;
         if (cap_tx[c] !== frame_bit(8'h55, 0, (c - 1) / 4))
            $display("[TB] FAIL gate55_tx cycle %0d got %b want %b", c, cap_tx[c], frame_bit(8'h55, 0, (c - 1) / 4));
         else passes++;
      end
      nrd = 0; nlow = 0; ndone = 0;
      for (int c = 1; c <= 60; c++) begin
         nrd   += int'(cap_rd[c]);
         ndone += int'(cap_done[c]);
      end
      for (int c = 41; c <= 60; c++) nlow += int'(!cap_tx[c]);
      checks++; if (cap_done[41] !== 1'b1 || ndone != 1) $display("[TB] FAIL gate_done got %b count %0d want 1 count 1", cap_done[41], ndone); else passes++;
      checks++; if (nrd != 0) $display("[TB] FAIL gate_no_repop got %0d want 0", nrd); else passes++;
      checks++; if (nlow != 0) $display("[TB] FAIL gate_tx_after got %0d low cycles want 0", nlow); else passes++;
   endtask

   task automatic test_reset_mid_frame();
      int nrd, nlow;
      en[0] = 1'b1;
      #1;
      checks++; if (rd[0] !== 1'b1) $display("[TB] FAIL rmid_pop81 got %b want 1", rd[0]); else passes++;
      capture(0, 1, 17);
      checks++; if (cap_tx[5] !== 1'b1 || cap_tx[17] !== 1'b0 || cap_busy[17] !== 1'b1) $display("[TB] FAIL rmid_pre got tx5 %b tx17 %b busy %b want 1 0 1", cap_tx[5], cap_tx[17], cap_busy[17]); else passes++;
      reset = 1'b1;
      #1;
      checks++; if (rd[0] !== 1'b0) $display("[TB] FAIL rmid_rd_in_reset got %b want 0", rd[0]); else passes++;
      step();
      checks++; if (tx[0] !== 1'b1) $display("[TB] FAIL rmid_tx got %b want 1", tx[0]); else passes++;
      checks++; if (busy[0] !== 1'b0) $display("[TB] FAIL rmid_busy got %b want 0", busy[0]); else passes++;
      checks++; if (tx_done[0] !== 1'b0) $display("[TB] FAIL rmid_done got %b want 0", tx_done[0]); else passes++;
      reset = 1'b0;
      #1;
      checks++; if (rd[0] !== 1'b1) $display("[TB] FAIL rmid_pop_release got %b want 1", rd[0]); else passes++;
      capture(0, 1, 41);
      for (int c = 1; c <= 40; c++) begin
         checks++;
         if (cap_tx[c] !== frame_bit(8'hC3, 0, (c - 1) / 4))
            $display("[TB] FAIL rmid_c3_tx cycle %0d got %b want %b", c, cap_tx[c], frame_bit(8'hC3, 0, (c - 1) / 4));
         else passes++;
      end
      checks++; if (cap_done[41] !== 1'b1) $display("[TB] FAIL rmid_c3_done got %b want 1", cap_done[41]); else passes++;
      capture(0, 42, 80);
      nrd = 0; nlow = 0;
      for (int c = 41; c <= 80; c++) begin
         nrd  += int'(cap_rd[c]);
         nlow += int'(!cap_tx[c]);
      end
      checks++; if (nrd != 0 || nlow != 0) $display("[TB] FAIL rmid_no_resend got pops %0d low %0d want 0 0", nrd, nlow); else passes++;
      checks++; if (popcnt[0] != 6 || wrp[0] != rdp[0]) $display("[TB] FAIL rmid_total_pops got %0d (wr %0d rd %0d) want 6", popcnt[0], wrp[0], rdp[0]); else passes++;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_parity();
      test_two_stop();
      test_enable_gating();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
